// File: rtl/tli4970_pkg.sv
// Shared definitions for the TLI4970 SPI poller: FSM states, Avalon register
// offsets, frame field positions and current-code decode helpers.
package tli4970_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SHIFT,
      ST_HOLD,
      ST_CAPTURE,
      ST_GAP
   } state_t;

   // Avalon-MM word offsets
   localparam logic [3:0] REG_CTRL      = 4'd0;
   localparam logic [3:0] REG_STATUS    = 4'd1;
   localparam logic [3:0] REG_FRAME_CNT = 4'd2;
   localparam logic [3:0] REG_CURRENT0  = 4'd4;

   // Sensor frame layout
   localparam int FRAME_TYPE_BIT   = 15;
   localparam int FRAME_PARITY_BIT = 14;
   localparam int FRAME_RSVD_BIT   = 13;
   localparam int CODE_MSB         = 12;

   // Zero current sits at mid-scale of the 13-bit code
   localparam int CODE_OFFSET = 4096;

   // Signed current from the raw 13-bit code, two's complement in 32 bits
   function automatic logic [31:0] code_to_current(input logic [CODE_MSB:0] code);
      return 32'(code) - 32'(CODE_OFFSET);
   endfunction

   // Even parity over the whole frame: total number of ones must be even
   function automatic logic parity_ok(input logic [15:0] frame);
      return ~(^frame);
   endfunction

endpackage

// File: rtl/tli4970_spi_shifter.sv
// SCK generator and 16-bit MSB-first receive shift register.
// Each bit is CLK_DIV cycles low then CLK_DIV cycles high; MISO is sampled
// on every falling edge, so a frame is exactly 16 rising and 16 falling edges.
module tli4970_spi_shifter #(
   parameter int CLK_DIV = 25
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        miso,
   output logic        sck,
   output logic        done,
   output logic [15:0] frame
);

   localparam int DIV_W = $clog2(CLK_DIV);

   logic             busy_reg;
   logic             sck_reg;
   logic             done_reg;
   logic [DIV_W-1:0] div_cnt_reg;
   logic [3:0]       bit_cnt_reg;
   logic [15:0]      shift_reg;
   logic             half_end;

   assign half_end = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

   // Half-period divider, SCK toggle, bit counter and shift register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_reg    <= 1'b0;
         sck_reg     <= 1'b0;
         done_reg    <= 1'b0;
         div_cnt_reg <= '0;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
      end else begin
         done_reg <= 1'b0;
         if (start && !busy_reg) begin
            busy_reg    <= 1'b1;
            sck_reg     <= 1'b0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
         end else if (busy_reg) begin
            if (half_end) begin
               div_cnt_reg <= '0;
               if (!sck_reg) begin
                  sck_reg <= 1'b1;
               end else begin
                  sck_reg   <= 1'b0;
                  shift_reg <= {shift_reg[14:0], miso};
                  if (bit_cnt_reg == 4'd15) begin
                     busy_reg <= 1'b0;
                     done_reg <= 1'b1;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                  end
               end
            end else begin
               div_cnt_reg <= div_cnt_reg + 1'b1;
            end
         end
      end
   end

   assign sck   = sck_reg;
   assign done  = done_reg;
   assign frame = shift_reg;

endmodule

// File: rtl/tli4970_spi_poller.sv
// Round-robin SPI poller for NUM_SENSORS TLI4970 current sensors with an
// Avalon-MM register file (CTRL, STATUS, FRAME_CNT, CURRENT[i]).
// Optional feature macro: TLI4970_PARITY_CHECK_EN -- when defined, type-0
// frames with bad parity set STATUS[idx] and are discarded; when undefined
// the parity bit is ignored and STATUS[7:0] always reads 0.
module tli4970_spi_poller
   import tli4970_pkg::*;
#(
   parameter int NUM_SENSORS  = 2,
   parameter int CLK_DIV      = 25,
   parameter int SETUP_CYCLES = 10,
   parameter int GAP_CYCLES   = 50
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [3:0]             avs_address,
   input  logic                   avs_read,
   output logic [31:0]            avs_readdata,
   input  logic                   avs_write,
   input  logic [31:0]            avs_writedata,
   input  logic                   miso,
   output logic                   sck,
   output logic [NUM_SENSORS-1:0] ss_n_o
);

   localparam int IDX_W   = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
   localparam int CNT_MAX = (GAP_CYCLES > SETUP_CYCLES) ? GAP_CYCLES : SETUP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t                        state_reg, state_next;
   logic [IDX_W-1:0]              idx_reg;
   logic [CNT_W-1:0]              cnt_reg;
   logic                          cnt_done;
   logic                          frame_active, sh_start, capture_en;
   logic                          sh_done;
   logic [15:0]                   sh_frame;
   logic                          ctrl_en_reg;
   logic [NUM_SENSORS-1:0]        err_reg, seen_reg;
   logic [31:0]                   frame_cnt_reg;
   logic [NUM_SENSORS-1:0][31:0]  current_all;
   logic [NUM_SENSORS-1:0]        idx_onehot, w1c_err, w1c_seen;
   logic                          parity_good, is_status, sts_wr;
   logic                          take_status, take_current, take_error;
   logic [31:0]                   rd_mux;
   logic                          unused_bits;

   tli4970_spi_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (sh_start),
      .miso    (miso),
      .sck     (sck),
      .done    (sh_done),
      .frame   (sh_frame)
   );

   // Wait-counter terminal count for the timed states
   always_comb begin
      cnt_done = 1'b0;
      case (state_reg)
         ST_SELECT, ST_HOLD: cnt_done = (cnt_reg == CNT_W'(SETUP_CYCLES - 1));
         ST_GAP:             cnt_done = (cnt_reg == CNT_W'(GAP_CYCLES - 1));
         default:            cnt_done = 1'b0;
      endcase
   end

   // State register, per-state wait counter and sensor index
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= (state_next != state_reg) ? '0 : cnt_reg + 1'b1;
         if (state_reg == ST_GAP && state_next != ST_GAP)
            idx_reg <= (idx_reg == IDX_W'(NUM_SENSORS - 1)) ? '0 : idx_reg + 1'b1;
      end
   end

   // Next state; enable is only looked at in IDLE and at the end of GAP so a
   // frame in flight always runs to completion
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (ctrl_en_reg) state_next = ST_SELECT;
         ST_SELECT:  if (cnt_done)    state_next = ST_SHIFT;
         ST_SHIFT:   if (sh_done)     state_next = ST_HOLD;
         ST_HOLD:    if (cnt_done)    state_next = ST_CAPTURE;
         ST_CAPTURE:                  state_next = ST_GAP;
         ST_GAP:     if (cnt_done)    state_next = ctrl_en_reg ? ST_SELECT : ST_IDLE;
         default:                     state_next = ST_IDLE;
      endcase
   end

   // FSM outputs: select window, shifter kick-off, capture strobe
   always_comb begin
      frame_active = 1'b0;
      sh_start     = 1'b0;
      capture_en   = 1'b0;
      case (state_reg)
         ST_SELECT: begin
            frame_active = 1'b1;
            sh_start     = cnt_done;
         end
         ST_SHIFT, ST_HOLD: frame_active = 1'b1;
         ST_CAPTURE:        capture_en   = 1'b1;
         default: ;
      endcase
   end

`ifdef TLI4970_PARITY_CHECK_EN
   assign parity_good = parity_ok(sh_frame);
`else
   assign parity_good = 1'b1;
`endif

   assign is_status    = sh_frame[FRAME_TYPE_BIT];
   assign take_status  = capture_en && is_status;
   assign take_current = capture_en && !is_status && parity_good;
   assign take_error   = capture_en && !is_status && !parity_good;
   assign idx_onehot   = NUM_SENSORS'(1) << idx_reg;

   assign sts_wr   = avs_write && (avs_address == REG_STATUS);
   assign w1c_err  = sts_wr ? avs_writedata[NUM_SENSORS-1:0] : '0;
   assign w1c_seen = sts_wr ? avs_writedata[8 +: NUM_SENSORS] : '0;

   // Reserved frame bit and high write-data bits carry no function
   assign unused_bits = ^{avs_writedata, sh_frame};

   // CTRL, sticky STATUS (a new event wins over a same-cycle clear), FRAME_CNT
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en_reg   <= 1'b0;
         err_reg       <= '0;
         seen_reg      <= '0;
         frame_cnt_reg <= '0;
      end else begin
         if (avs_write && avs_address == REG_CTRL)
            ctrl_en_reg <= avs_writedata[0];
         err_reg  <= (err_reg  & ~w1c_err)  | (take_error  ? idx_onehot : '0);
         seen_reg <= (seen_reg & ~w1c_seen) | (take_status ? idx_onehot : '0);
         if (take_status || take_current)
            frame_cnt_reg <= frame_cnt_reg + 32'd1;
      end
   end

   for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
      logic [31:0] current_reg;

      // Latest decoded current for this sensor
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            current_reg <= '0;
         else if (take_current && idx_reg == IDX_W'(gi))
            current_reg <= code_to_current(sh_frame[CODE_MSB:0]);
      end

      assign current_all[gi] = current_reg;
      assign ss_n_o[gi]      = !(frame_active && idx_reg == IDX_W'(gi));
   end

   // Read decode; unused addresses return 0
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         REG_CTRL:      rd_mux[0] = ctrl_en_reg;
         REG_STATUS: begin
            rd_mux[NUM_SENSORS-1:0]  = err_reg;
            rd_mux[8 +: NUM_SENSORS] = seen_reg;
         end
         REG_FRAME_CNT: rd_mux = frame_cnt_reg;
         default: begin
            for (int i = 0; i < NUM_SENSORS; i++)
               if (avs_address == 4'(REG_CURRENT0 + i))
                  rd_mux = current_all[i];
         end
      endcase
   end

   // Registered read data, so a read during CAPTURE sees the old value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         avs_readdata <= '0;
      else
         avs_readdata <= avs_read ? rd_mux : 32'd0;
   end

endmodule

// File: tb/tb_tli4970_spi_poller.sv
// Bench for tli4970_spi_poller: sensor model on MISO, frame monitor and a
// frame-level reference model of the register file.
module tb_tli4970_spi_poller;

   localparam int NS      = 2;
   localparam int CLK_DIV = 25;
   localparam int SETUP   = 10;
   localparam int GAP     = 50;
`ifdef TLI4970_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [3:0]    avs_address = '0;
   logic          avs_read = 1'b0;
   logic          avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic [31:0]   avs_readdata;
   logic          miso = 1'b0;
   logic          sck;
   logic [NS-1:0] ss_n_o;

   int total = 0;
   int bad   = 0;

   // sensor words (main) and reference model state (monitor)
   logic [15:0]   sensor_word [NS];
   int            m_current [NS];
   logic [NS-1:0] m_err = '0;
   logic [NS-1:0] m_seen = '0;
   int unsigned   m_cnt = 0;
   int            frames_done = 0;
   logic [31:0]   w1c_val = '0;
   int            w1c_seq = 0;
   int            exp_idx = 0;

   // monitor observations of the last frame
   int            act = -1;
   int            bitpos = 0;
   logic [15:0]   cur_word = '0;
   int            rises = 0, falls = 0;
   int            last_rises = 0, last_falls = 0, last_period = 0, last_gap = 0;
   logic [NS-1:0] last_sel = '1;
   int            gap_cnt = 0;
   int            cyc = 0, t_rise1 = 0;
   int            w1c_done = 0;
   logic          sck_d = 1'b0;
   logic [NS-1:0] ss_d = '1;

   tli4970_spi_poller #(
      .NUM_SENSORS  (NS),
      .CLK_DIV      (CLK_DIV),
      .SETUP_CYCLES (SETUP),
      .GAP_CYCLES   (GAP)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .avs_address   (avs_address),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .miso          (miso),
      .sck           (sck),
      .ss_n_o        (ss_n_o)
   );

   always #5 clk = ~clk;

   // Sensors, frame monitor and reference model, evaluated on the falling clk edge
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         act    = -1;
         miso   = 1'b0;
         gap_cnt = 0;
         m_err  = '0;
         m_seen = '0;
         m_cnt  = 0;
         for (int i = 0; i < NS; i++) m_current[i] = 0;
      end else begin
         if (w1c_done != w1c_seq) begin
            m_err  = m_err  & ~w1c_val[NS-1:0];
            m_seen = m_seen & ~w1c_val[8 +: NS];
            w1c_done = w1c_seq;
         end
         if (ss_d == '1 && ss_n_o != '1) begin
            last_gap = gap_cnt;
            last_sel = ss_n_o;
            for (int i = 0; i < NS; i++) if (!ss_n_o[i]) act = i;
            cur_word = sensor_word[act];
            bitpos = 15;
            rises = 0;
            falls = 0;
         end else if (ss_d != '1 && ss_n_o == '1 && act >= 0) begin
            last_rises = rises;
            last_falls = falls;
            if (cur_word[15]) begin
               m_seen[act] = 1'b1;
               m_cnt++;
            end else if (PAR_EN && ($countones(cur_word) % 2 == 1)) begin
               m_err[act] = 1'b1;
            end else begin
               m_current[act] = int'({19'b0, cur_word[12:0]}) - 4096;
               m_cnt++;
            end
            frames_done++;
            act = -1;
            gap_cnt = 0;
         end
         if (act >= 0) begin
            if (!sck_d && sck) begin
               rises++;
               if (rises == 1) t_rise1 = cyc;
               if (rises == 2) last_period = cyc - t_rise1;
            end
            if (sck_d && !sck) begin
               falls++;
               bitpos--;
            end
         end
         if (ss_n_o == '1) gap_cnt++;
         miso = (act >= 0 && bitpos >= 0) ? cur_word[bitpos] : 1'b0;
      end
      sck_d = sck;
      ss_d  = ss_n_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read = 1'b0;
      d = avs_readdata;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] v);
      avs_address   = a;
      avs_writedata = v;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic wait_frame();
      int target = frames_done + 1;
      int n = 0;
      while (frames_done < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("frame_timeout", 32'(frames_done >= target), 32'd1);
   endtask

   task automatic wait_rises(input int k);
      int n = 0;
      while (!(act >= 0 && rises >= k) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("rise_timeout", 32'(act >= 0 && rises >= k), 32'd1);
   endtask

   task automatic check_regs(input string where);
      logic [31:0] d;
      logic [31:0] exp_sts;
      exp_sts = '0;
      exp_sts[NS-1:0] = m_err;
      exp_sts[8 +: NS] = m_seen;
      rd(4'd2, d);
      check({where, "_frame_cnt"}, d, m_cnt);
      rd(4'd1, d);
      check({where, "_status"}, d, exp_sts);
      for (int i = 0; i < NS; i++) begin
         rd(4'(4 + i), d);
         check($sformatf("%s_current%0d", where, i), d, 32'(m_current[i]));
      end
   endtask

   task automatic check_frame(input bit gap_ok);
      logic [NS-1:0] es;
      es = '1;
      es[exp_idx] = 1'b0;
      check("ss_walk", 32'(last_sel), 32'(es));
      check("sck_rises", 32'(last_rises), 32'd16);
      check("sck_falls", 32'(last_falls), 32'd16);
      check("sck_period", 32'(last_period), 32'(2 * CLK_DIV));
      if (gap_ok)
         check("gap_len", 32'(last_gap >= GAP && last_gap <= GAP + 1), 32'd1);
      exp_idx = (exp_idx + 1) % NS;
      check_regs("frm");
   endtask

   task automatic step(input logic [15:0] w0, input logic [15:0] w1, input bit gap_ok);
      sensor_word[0] = w0;
      sensor_word[1] = w1;
      wait_frame();
      check_frame(gap_ok);
   endtask

   task automatic clear_status(input logic [31:0] v);
      w1c_val = v;
      w1c_seq++;
      wr(4'd1, v);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] d;
      int fd;
      sensor_word[0] = '0;
      sensor_word[1] = '0;
      for (int i = 0; i < NS; i++) m_current[i] = 0;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_ss", 32'(ss_n_o), 32'(2'b11));
      check("rst_readdata", avs_readdata, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      rd(4'd0, d);
      check("rst_ctrl", d, 32'd0);
      check_regs("rst");

      // read-only and unused addresses ignore writes and read 0
      wr(4'd2, 32'hFFFF_FFFF);
      wr(4'd3, 32'hFFFF_FFFF);
      rd(4'd2, d);
      check("ro_frame_cnt", d, 32'd0);
      rd(4'd3, d);
      check("unused_addr", d, 32'd0);

      // zero-current frames from both sensors
      wr(4'd0, 32'd1);
      rd(4'd0, d);
      check("ctrl_en", d, 32'd1);
      step(16'h3000, 16'h5000, 1'b0);
      step(16'h3000, 16'h5000, 1'b1);

      // full-scale codes
      step(16'h0001, 16'h0001, 1'b1);
      step(16'h1FFF, 16'h1FFF, 1'b1);

      // parity-error candidate on sensor 1, then W1C of STATUS[1]
      step(16'h3000, 16'h1000, 1'b1);
      step(16'h3000, 16'h1000, 1'b1);
      clear_status(32'h0000_0002);
      rd(4'd1, d);
      check("w1c_status", d, {16'b0, 6'b0, m_seen, 6'b0, m_err});

      // status frame from sensor 0, then clear the seen bit
      step(16'h8000, 16'h3000, 1'b1);
      clear_status(32'h0000_0100);
      rd(4'd1, d);
      check("w1c_seen", d, {16'b0, 6'b0, m_seen, 6'b0, m_err});

      // randomized frames
      for (int k = 0; k < 8; k++) begin
         step(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b1);
         if (k == 4) clear_status(32'h0000_FFFF);
      end

      // clear enable during bit 5 of a frame: frame still completes
      sensor_word[0] = 16'h2345;
      sensor_word[1] = 16'h2345;
      wait_rises(6);
      wr(4'd0, 32'd0);
      wait_frame();
      check_frame(1'b1);
      fd = frames_done;
      repeat (GAP + 40) @(negedge clk);
      check("idle_ss", 32'(ss_n_o), 32'(2'b11));
      check("idle_no_frame", 32'(frames_done), 32'(fd));
      rd(4'd0, d);
      check("idle_ctrl", d, 32'd0);

      // asynchronous reset during SHIFT
      wr(4'd0, 32'd1);
      wait_rises(3);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_sck", 32'(sck), 32'd0);
      check("arst_ss", 32'(ss_n_o), 32'(2'b11));
      @(negedge clk);
      @(negedge clk);
      exp_idx = 0;
      reset_n = 1'b1;
      @(negedge clk);
      rd(4'd0, d);
      check("arst_ctrl", d, 32'd0);
      check_regs("arst");

      // polling restarts at sensor 0
      wr(4'd0, 32'd1);
      step(16'h0ABC, 16'h0ABC, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
